// File: rtl/fpu_op_pipe.sv
// fpu_op_pipe: handshaked front-end around a combinational single-precision
// datapath (add/sub/mul/div). A capture stage registers one op. A divide is
// held there for DIV_CYCLES cycles. The selected result and its tag then move
// through PIPE_STAGES output registers that shift together under a single
// stall enable.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds valid and its payload stable until the transfer.
// Ready never depends on the same-side valid. This applies to the request side
// (i_vld/o_rdy) and to the result side (o_vld/i_rdy).
//
// Ports:
//   i_clk, i_rstn    clock (rising edge), asynchronous active-low reset
//   i_flush          synchronous flush of every in-flight op
//   i_vld/o_rdy      request handshake; i_op 0=ADD 1=SUB 2=MUL 3=DIV
//   i_op1, i_op2     IEEE-754 single operands
//   i_tag            sideband tag, returned with the result
//   o_vld/i_rdy      result handshake; o_res result, o_tag its tag
//   o_busy           capture stage or any output stage occupied
//
// Datapath: normal and zero operands are handled with round-to-nearest-even.
// Subnormal inputs and underflowing results are flushed to signed zero.
// Infinite or NaN inputs produce the canonical quiet NaN.
module fpu_op_pipe #(
    parameter int PIPE_STAGES = 2,
    parameter int DIV_CYCLES  = 4,
    parameter int TAG_W       = 4
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_flush,
    input  logic             i_vld,
    output logic             o_rdy,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_op1,
    input  logic [31:0]      i_op2,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_vld,
    input  logic             i_rdy,
    output logic [31:0]      o_res,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);
    localparam int              CNT_W    = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [1:0]      OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
    localparam logic [31:0]     QNAN   = 32'h7FC0_0000;

    // Round to nearest even and pack. m carries its leading one at bit 26;
    // bits [2:0] are guard, round and sticky.
    function automatic logic [31:0] f_pack(input logic s, input logic signed [10:0] e,
                                           input logic [26:0] m);
        logic [24:0]        r;
        logic signed [10:0] ee;
        r  = {1'b0, m[26:3]} + 25'(m[2] & (m[1] | m[0] | m[3]));
        ee = e;
        if (r[24]) begin
            r  = r >> 1;
            ee = ee + 11'sd1;
        end
        if (m == 27'd0 || ee <= 0) f_pack = {s, 31'd0};
        else if (ee >= 255)        f_pack = {s, 8'hFF, 23'd0};
        else                       f_pack = {s, ee[7:0], r[22:0]};
    endfunction

    function automatic logic [31:0] f_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        x, y;
        logic [26:0]        mx, my, sh;
        logic [27:0]        s;
        logic [7:0]         d;
        logic signed [10:0] e;
        // x is the operand of larger magnitude, so the sum takes its sign.
        if (b[30:0] > a[30:0]) begin x = b; y = a; end
        else                   begin x = a; y = b; end
        mx = (x[30:23] != 8'd0) ? {1'b1, x[22:0], 3'b0} : 27'd0;
        my = (y[30:23] != 8'd0) ? {1'b1, y[22:0], 3'b0} : 27'd0;
        d  = x[30:23] - y[30:23];
        sh = (d > 8'd26) ? 27'd0 : (my >> d);
        sh[0] = sh[0] | ((d > 8'd26) ? (my != 27'd0) : ((sh << d) != my));
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, sh};
        else                s = {1'b0, mx} - {1'b0, sh};
        e = 11'(x[30:23]);
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 11'sd1;
        end
        for (int i = 0; i < 26; i++) begin
            if (!s[26] && s != 28'd0) begin
                s = s << 1;
                e = e - 11'sd1;
            end
        end
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) f_add = QNAN;
        else f_add = f_pack(x[31] & (s != 28'd0), e, s[26:0]);
    endfunction

    function automatic logic [31:0] f_mul(input logic [31:0] a, input logic [31:0] b);
        logic [47:0]        p;
        logic [26:0]        m;
        logic signed [10:0] e;
        p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
        e = 11'(a[30:23]) + 11'(b[30:23]) - 11'd127;
        if (p[47]) begin
            m = {p[47:22], |p[21:0]};
            e = e + 11'sd1;
        end else begin
            m = {p[46:21], |p[20:0]};
        end
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF)    f_mul = QNAN;
        else if (a[30:23] == 8'd0 || b[30:23] == 8'd0) f_mul = {a[31] ^ b[31], 31'd0};
        else                                           f_mul = f_pack(a[31] ^ b[31], e, m);
    endfunction

    function automatic logic [31:0] f_div(input logic [31:0] a, input logic [31:0] b);
        logic [50:0]        n, dv;
        logic [27:0]        q;
        logic               rem_nz;
        logic [26:0]        m;
        logic signed [10:0] e;
        // Scaling the dividend by 2^27 leaves the quotient in [2^26, 2^28).
        n      = {1'b1, a[22:0], 27'd0};
        dv     = {27'd0, 1'b1, b[22:0]};
        q      = 28'(n / dv);
        rem_nz = (n % dv) != 51'd0;
        e      = 11'(a[30:23]) - 11'(b[30:23]) + (q[27] ? 11'd127 : 11'd126);
        m      = q[27] ? {q[27:2], q[1] | q[0] | rem_nz} : {q[26:1], q[0] | rem_nz};
        if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) f_div = QNAN;
        else if (b[30:23] == 8'd0) f_div = (a[30:23] == 8'd0) ? QNAN : {a[31] ^ b[31], 8'hFF, 23'd0};
        else if (a[30:23] == 8'd0) f_div = {a[31] ^ b[31], 31'd0};
        else                       f_div = f_pack(a[31] ^ b[31], e, m);
    endfunction

    typedef enum logic {ST_IDLE, ST_HOLD} state_t;

    state_t           state_q, state_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [1:0]       op_q, op_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PIPE_STAGES-1:0] vld_q, vld_d;
    logic [31:0]      res_q  [PIPE_STAGES];
    logic [31:0]      res_d  [PIPE_STAGES];
    logic [TAG_W-1:0] ptag_q [PIPE_STAGES];
    logic [TAG_W-1:0] ptag_d [PIPE_STAGES];

    logic        en, done, push;
    logic [31:0] sel_res;

    always_comb begin
        sel_res = f_add(a_q, b_q);
        case (op_q)
            OP_ADD:  sel_res = f_add(a_q, b_q);
            OP_SUB:  sel_res = f_add(a_q, {~b_q[31], b_q[30:0]});
            OP_MUL:  sel_res = f_mul(a_q, b_q);
            default: sel_res = f_div(a_q, b_q);
        endcase
    end

    assign o_vld  = vld_q[PIPE_STAGES-1];
    assign o_res  = res_q[PIPE_STAGES-1];
    assign o_tag  = ptag_q[PIPE_STAGES-1];
    assign en     = ~o_vld | i_rdy;
    // The count saturates at CNT_LAST, so done stays high while a stall holds the op.
    assign done   = (op_q != OP_DIV) || (cnt_q == CNT_LAST);
    assign push   = (state_q == ST_HOLD) && done && en;
    assign o_rdy  = ~i_flush & ((state_q == ST_IDLE) | push);
    assign o_busy = (state_q == ST_HOLD) | (|vld_q);

    // Capture stage
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        if (state_q == ST_HOLD && !done) cnt_d = cnt_q + 1'b1;
        if (push) state_d = ST_IDLE;
        if (i_vld && o_rdy) begin
            state_d = ST_HOLD;
            a_d     = i_op1;
            b_d     = i_op2;
            op_d    = i_op;
            tag_d   = i_tag;
            cnt_d   = '0;
        end
        if (i_flush) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end
    end

    // Output stages. Data moves only behind a valid entry, so the last stage
    // keeps showing the most recent result after it retires. A flush holds the
    // data as well as clearing the valids.
    always_comb begin
        vld_d  = vld_q;
        res_d  = res_q;
        ptag_d = ptag_q;
        if (en && !i_flush) begin
            vld_d[0] = push;
            if (push) begin
                res_d[0]  = sel_res;
                ptag_d[0] = tag_q;
            end
            for (int i = 1; i < PIPE_STAGES; i++) begin
                vld_d[i] = vld_q[i-1];
                if (vld_q[i-1]) begin
                    res_d[i]  = res_q[i-1];
                    ptag_d[i] = ptag_q[i-1];
                end
            end
        end
        if (i_flush) vld_d = '0;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            tag_q   <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
            for (int i = 0; i < PIPE_STAGES; i++) begin
                res_q[i]  <= '0;
                ptag_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            vld_q   <= vld_d;
            res_q   <= res_d;
            ptag_q  <= ptag_d;
        end
    end

endmodule

// File: tb/tb_fpu_op_pipe.sv
module tb_fpu_op_pipe;
  localparam int TAG_W = 4;
  localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;
  localparam logic [31:0] F1 = 32'h3F80_0000, F2 = 32'h4000_0000, F3 = 32'h4040_0000;
  localparam logic [31:0] F4 = 32'h4080_0000, F6 = 32'h40C0_0000;

  logic             clk = 1'b0;
  logic             i_rstn, i_flush, i_vld, i_rdy;
  logic [1:0]       i_op;
  logic [31:0]      i_op1, i_op2;
  logic [TAG_W-1:0] i_tag;
  logic             o_rdy, o_vld, o_busy;
  logic [31:0]      o_res;
  logic [TAG_W-1:0] o_tag;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [TAG_W+31:0] exp_q[$];
  logic [TAG_W+31:0] mon_exp;

  fpu_op_pipe #(.PIPE_STAGES(2), .DIV_CYCLES(4), .TAG_W(TAG_W)) dut (
    .i_clk(clk), .i_rstn(i_rstn), .i_flush(i_flush), .i_vld(i_vld), .o_rdy(o_rdy),
    .i_op(i_op), .i_op1(i_op1), .i_op2(i_op2), .i_tag(i_tag), .o_vld(o_vld),
    .i_rdy(i_rdy), .o_res(o_res), .o_tag(o_tag), .o_busy(o_busy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // scoreboard: every retired result must match the head of exp_q
  always @(negedge clk) begin
    if (o_vld && i_rdy) begin
      if (exp_q.size() == 0) begin
        check("spurious_vld", {63'd0, o_vld}, 64'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("result", {28'd0, o_tag, o_res}, {28'd0, mon_exp});
      end
    end
  end

  // driver tasks
  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag, input logic [31:0] exp_res,
                       output int acc, output int stalls);
    stalls = 0;
    i_vld = 1'b1; i_op = op; i_op1 = a; i_op2 = b; i_tag = tag;
    @(negedge clk);
    while (!o_rdy && stalls < 100) begin
      stalls++;
      @(negedge clk);
    end
    if (!o_rdy) check("issue_timeout", {63'd0, o_rdy}, 64'd1);
    exp_q.push_back({tag, exp_res});
    @(posedge clk); #1;
    acc = cyc;
    i_vld = 1'b0;
  endtask

  task automatic wait_vld(output int m);
    int n = 0;
    @(negedge clk);
    while (!o_vld && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!o_vld) check("vld_timeout", {63'd0, o_vld}, 64'd1);
    m = cyc;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || o_busy) && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int acc, acc2, st, m;
    i_rstn = 1'b0; i_flush = 1'b0; i_vld = 1'b0; i_rdy = 1'b1;
    i_op = '0; i_op1 = '0; i_op2 = '0; i_tag = '0;

    // reset state
    repeat (3) @(posedge clk); #1;
    check("rst_vld", {63'd0, o_vld}, 64'd0);
    check("rst_busy", {63'd0, o_busy}, 64'd0);
    check("rst_res", {32'd0, o_res}, 64'd0);
    check("rst_tag", {60'd0, o_tag}, 64'd0);
    i_rstn = 1'b1;
    @(negedge clk);
    check("rst_rdy", {63'd0, o_rdy}, 64'd1);
    @(posedge clk); #1;

    // single ADD: 1.0 + 2.0 = 3.0, tag 5, three edges
    issue(OP_ADD, F1, F2, 4'd5, F3, acc, st);
    wait_vld(m);
    check("add_latency", 64'(m - acc + 1), 64'd3);
    drain();

    // SUB, MUL, ADD on consecutive cycles retire on consecutive cycles
    issue(OP_SUB, F3, F1, 4'd1, F2, acc, st);
    issue(OP_MUL, F2, F3, 4'd2, F6, acc, st);
    issue(OP_ADD, F1, F1, 4'd3, F2, acc, st);
    wait_vld(m);
    @(negedge clk);
    check("burst_vld2", {63'd0, o_vld}, 64'd1);
    @(negedge clk);
    check("burst_vld3", {63'd0, o_vld}, 64'd1);
    drain();

    // DIV 6.0 / 2.0 blocks issue for three cycles; queued ADD follows
    issue(OP_DIV, F6, F2, 4'd6, F3, acc, st);
    issue(OP_ADD, F1, F2, 4'd7, F3, acc2, st);
    check("div_rdy_low", 64'(st), 64'd3);
    check("div_add_accept", 64'(acc2 - acc), 64'd4);
    wait_vld(m);
    check("div_latency", 64'(m - acc + 1), 64'd6);
    drain();

    // consumer stalls for six cycles while four ADDs are offered
    i_rdy = 1'b0;
    fork
      begin
        issue(OP_ADD, F1, F1, 4'd0, F2, acc, st);
        issue(OP_ADD, F1, F2, 4'd1, F3, acc, st);
        issue(OP_ADD, F2, F2, 4'd2, F4, acc, st);
        issue(OP_ADD, F2, F4, 4'd3, F6, acc, st);
        check("stall_rdy_dropped", {63'd0, st > 0}, 64'd1);
      end
      begin
        repeat (6) begin
          @(negedge clk);
          if (o_vld) check("stall_hold", {28'd0, o_tag, o_res}, {28'd0, 4'd0, F2});
        end
        @(posedge clk); #1;
        i_rdy = 1'b1;
      end
    join
    drain();

    // flush with a DIV in capture and two ops in the output stages
    i_rdy = 1'b0;
    issue(OP_ADD, F1, F1, 4'd1, F2, acc, st);
    issue(OP_ADD, F1, F2, 4'd2, F3, acc, st);
    issue(OP_DIV, F6, F2, 4'd3, F3, acc, st);
    i_flush = 1'b1;
    i_vld = 1'b1; i_op = OP_ADD; i_op1 = F2; i_op2 = F2; i_tag = 4'hF;
    @(negedge clk);
    check("flush_rdy", {63'd0, o_rdy}, 64'd0);
    @(posedge clk); #1;
    i_flush = 1'b0;
    i_vld = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("flush_vld", {63'd0, o_vld}, 64'd0);
    check("flush_busy", {63'd0, o_busy}, 64'd0);
    check("flush_rdy_after", {63'd0, o_rdy}, 64'd1);
    check("flush_res_kept", {28'd0, o_tag, o_res}, {28'd0, 4'd1, F2});
    @(posedge clk); #1;
    i_rdy = 1'b1;
    repeat (12) @(negedge clk);
    check("flush_quiet", {63'd0, o_busy}, 64'd0);
    @(posedge clk); #1;

    // asynchronous reset in the middle of a DIV
    issue(OP_DIV, F6, F2, 4'd4, F3, acc, st);
    repeat (2) @(negedge clk);
    #2;
    i_rstn = 1'b0;
    #1;
    check("arst_vld", {63'd0, o_vld}, 64'd0);
    check("arst_busy", {63'd0, o_busy}, 64'd0);
    check("arst_res", {32'd0, o_res}, 64'd0);
    exp_q.delete();
    @(posedge clk); #1;
    i_rstn = 1'b1;
    issue(OP_MUL, F2, F3, 4'd9, F6, acc, st);
    wait_vld(m);
    check("post_reset_latency", 64'(m - acc + 1), 64'd3);
    drain();
    repeat (10) @(negedge clk);
    check("post_reset_quiet", {63'd0, o_busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
